add_tree_acc: RTL

ADD_TREE_ACC -- requirements
Module: add_tree_acc

---
 rtl/add_tree_acc.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/add_tree_acc.sv
// Pipelined N-operand adder tree with a grouped accumulator on its output.
// Each beat carries its own signed/unsigned mode; a group latches its mode on the first beat.
module add_tree_acc #(
   parameter int unsigned WIDTH = 12,
   parameter int unsigned N     = 8,
   parameter int unsigned ACCW  = 24
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   input  logic [N*WIDTH-1:0]            in_data,
   input  logic                          sus,
   input  logic                          in_first,
   input  logic                          in_last,
   output logic                          tree_valid,
   output logic [WIDTH+$clog2(N)-1:0]    tree_sum,
   output logic                          acc_valid,
   output logic [ACCW-1:0]               acc_sum,
   output logic                          acc_ovf
);

   localparam int unsigned LOG2N = $clog2(N);
   localparam int unsigned TW    = WIDTH + LOG2N;

   if ((N < 2) || ((1 << LOG2N) != N) || (WIDTH < 2) || (ACCW < TW)) begin : g_param_err
      $error("add_tree_acc: illegal WIDTH/N/ACCW combination");
   end

   // Sideband registers sit alongside each tree stage register.
   logic [LOG2N-1:0] vld_q, sus_q, fst_q, lst_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q <= '0;
         sus_q <= '0;
         fst_q <= '0;
         lst_q <= '0;
      end else begin
         vld_q[0] <= in_valid;
         sus_q[0] <= sus;
         fst_q[0] <= in_first;
         lst_q[0] <= in_last;
         for (int k = 1; k < LOG2N; k++) begin
            vld_q[k] <= vld_q[k-1];
            sus_q[k] <= sus_q[k-1];
            fst_q[k] <= fst_q[k-1];
            lst_q[k] <= lst_q[k-1];
         end
      end
   end

   for (genvar k = 0; k < LOG2N; k++) begin : g_stage
      localparam int unsigned IW = WIDTH + k;
      localparam int unsigned OW = IW + 1;
      localparam int unsigned NO = N >> (k + 1);

      logic [2*NO*IW-1:0] src;
      logic               src_vld;
      logic               src_sus;
      logic [NO*OW-1:0]   sum_d;
      logic [NO*OW-1:0]   sum_q;

      if (k == 0) begin : g_in
         assign src     = in_data;
         assign src_vld = in_valid;
         assign src_sus = sus;
      end else begin : g_mid
         assign src     = g_stage[k-1].sum_q;
         assign src_vld = vld_q[k-1];
         assign src_sus = sus_q[k-1];
      end

      // One extra bit per stage keeps every add exact.
      always_comb begin
         sum_d = '0;
         for (int i = 0; i < NO; i++) begin
            sum_d[i*OW +: OW] = {src_sus & src[(2*i+1)*IW-1], src[2*i*IW +: IW]}
                              + {src_sus & src[(2*i+2)*IW-1], src[(2*i+1)*IW +: IW]};
         end
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            sum_q <= '0;
         end else if (src_vld) begin
            sum_q <= sum_d;
         end
      end
   end

   assign tree_valid = vld_q[LOG2N-1];
   assign tree_sum   = g_stage[LOG2N-1].sum_q;

   logic            beat_first, beat_last, beat_sus;
   logic [ACCW-1:0] acc_q, acc_d, ext;
   logic [ACCW:0]   add;
   logic            mode_q, mode_d, ovf_q, ovf_d, accv_q;

   assign beat_first = fst_q[LOG2N-1];
   assign beat_last  = lst_q[LOG2N-1];
   assign beat_sus   = sus_q[LOG2N-1];

   always_comb begin
      mode_d = mode_q;
      acc_d  = acc_q;
      ovf_d  = ovf_q;
      if (tree_valid && beat_first) begin
         mode_d = beat_sus;
      end
      ext = mode_d ? ACCW'($signed(tree_sum)) : ACCW'(tree_sum);
      add = {1'b0, acc_q} + {1'b0, ext};
      if (tree_valid) begin
         if (beat_first) begin
            acc_d = ext;
            ovf_d = 1'b0;
         end else begin
            acc_d = add[ACCW-1:0];
            if (mode_q) begin
               ovf_d = ovf_q | ((acc_q[ACCW-1] == ext[ACCW-1]) && (add[ACCW-1] != acc_q[ACCW-1]));
            end else begin
               ovf_d = ovf_q | add[ACCW];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q  <= '0;
         mode_q <= 1'b0;
         ovf_q  <= 1'b0;
         accv_q <= 1'b0;
      end else begin
         acc_q  <= acc_d;
         mode_q <= mode_d;
         ovf_q  <= ovf_d;
         accv_q <= tree_valid & beat_last;
      end
   end

   assign acc_valid = accv_q;
   assign acc_sum   = acc_q;
   assign acc_ovf   = ovf_q;

endmodule
